// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout serializer slice.
// Optional feature macro used by this slice: READOUT_PARITY_EN (even parity bit per frame).
package readout_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_CLK_DIV    = 1;
   localparam int DEF_GAP_BITS   = 1;

   // Bits needed for a counter running 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO with push/pop, full/empty and an explicit level count.
// Head word is visible combinationally so the consumer can load it on the pop edge.
module readout_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;
   logic              do_push;
   logic              do_pop;

   assign full      = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty     = (level_reg == '0);
   assign level     = level_reg;
   assign head_data = mem[rd_ptr_reg];

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage array; no reset needed, contents are qualified by level.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; level tracked separately.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/readout_serializer.sv
// Readout serializer: buffers words in a FIFO and shifts each out MSB-first
// with frame and per-bit strobe qualifiers, all driven from flops.
// Define READOUT_PARITY_EN to append an even-parity bit to every frame.
module readout_serializer
   import readout_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int GAP_BITS   = DEF_GAP_BITS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          ser_data,
   output logic                          ser_frame,
   output logic                          ser_strobe,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef READOUT_PARITY_EN
   localparam int SH_W = DATA_W + 1;
`else
   localparam int SH_W = DATA_W;
`endif
   localparam int NBITS   = SH_W;
   localparam int GAP_CYC = GAP_BITS * CLK_DIV;
   localparam int DIV_W   = cnt_w(CLK_DIV);
   localparam int BIT_W   = cnt_w(NBITS);
   localparam int GAP_W   = cnt_w(GAP_CYC);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   state_t            state_reg;
   logic [SH_W-1:0]   shreg_reg;
   logic [DIV_W-1:0]  div_reg;
   logic [BIT_W-1:0]  bit_reg;
   logic [GAP_W-1:0]  gap_reg;
   logic              ser_data_reg;
   logic              ser_frame_reg;
   logic              ser_strobe_reg;

   logic [DATA_W-1:0] head_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [SH_W-1:0]   load_word;

   readout_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s_valid),
      .push_data (s_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // The parity bit rides as the shift register's trailing bit.
`ifdef READOUT_PARITY_EN
   assign load_word = {head_data, ^head_data};
`else
   assign load_word = head_data;
`endif

   // New frames start only from IDLE, so ena never truncates a frame in flight.
   assign pop        = (state_reg == IDLE) && ena && !fifo_empty;
   assign s_ready    = !fifo_full;
   assign busy       = (state_reg != IDLE) || (fifo_level != '0);
   assign ser_data   = ser_data_reg;
   assign ser_frame  = ser_frame_reg;
   assign ser_strobe = ser_strobe_reg;

   // Frame FSM with divider, bit counter, shift register and registered serial outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         shreg_reg      <= '0;
         div_reg        <= '0;
         bit_reg        <= '0;
         gap_reg        <= '0;
         ser_data_reg   <= 1'b0;
         ser_frame_reg  <= 1'b0;
         ser_strobe_reg <= 1'b0;
      end else begin
         ser_data_reg   <= 1'b0;
         ser_frame_reg  <= 1'b0;
         ser_strobe_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  shreg_reg <= load_word;
                  div_reg   <= '0;
                  bit_reg   <= '0;
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               ser_frame_reg  <= 1'b1;
               ser_data_reg   <= shreg_reg[SH_W-1];
               ser_strobe_reg <= (div_reg == '0);
               if (div_reg == DIV_LAST) begin
                  div_reg   <= '0;
                  shreg_reg <= shreg_reg << 1;
                  if (bit_reg == BIT_LAST) begin
                     bit_reg   <= '0;
                     gap_reg   <= '0;
                     state_reg <= GAP;
                  end else begin
                     bit_reg <= bit_reg + 1'b1;
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            GAP: begin
               if (gap_reg == GAP_LAST) begin
                  state_reg <= IDLE;
               end else begin
                  gap_reg <= gap_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_readout_serializer.sv
// Directed bench for readout_serializer with a word scoreboard and a frame monitor.
// Two instances: CLK_DIV=1 for the main scenarios, CLK_DIV=3 for bit stretching.
module tb_readout_serializer;

`ifdef READOUT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB1 = 8 + PAR;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready, ser_data, ser_frame, ser_strobe, busy;
   logic [2:0] fifo_level;

   logic       ena3;
   logic [7:0] s_data3;
   logic       s_valid3;
   logic       s_ready3, ser_data3, ser_frame3, ser_strobe3, busy3;
   logic [2:0] fifo_level3;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb_q[$];
   int         gap_q[$];

   always #5 clk = ~clk;

   readout_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(1), .GAP_BITS(1)) dut (
      .clk(clk), .rst(rst), .ena(ena), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .ser_data(ser_data), .ser_frame(ser_frame),
      .ser_strobe(ser_strobe), .busy(busy), .fifo_level(fifo_level)
   );

   readout_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(3), .GAP_BITS(1)) dut3 (
      .clk(clk), .rst(rst), .ena(ena3), .s_data(s_data3), .s_valid(s_valid3),
      .s_ready(s_ready3), .ser_data(ser_data3), .ser_frame(ser_frame3),
      .ser_strobe(ser_strobe3), .busy(busy3), .fifo_level(fifo_level3)
   );

   function automatic logic [8:0] frame_bits(input logic [7:0] w);
      if (PAR != 0) return {w, ^w};
      else return {1'b0, w};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit exp_acc);
      s_data  = d;
      s_valid = 1'b1;
      if (exp_acc) sb_q.push_back(d);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 400), 1);
      repeat (2) @(negedge clk);
   endtask

   // Frame monitor for the CLK_DIV=1 instance: collects each frame and scores it.
   logic [8:0] mon_obs;
   int         mon_nb, mon_nstb, low_run;
   bit         in_frame = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         low_run  = 0;
      end else if (ser_frame) begin
         if (!in_frame) begin
            gap_q.push_back(low_run);
            mon_obs  = '0;
            mon_nb   = 0;
            mon_nstb = 0;
            in_frame = 1'b1;
         end
         mon_obs = {mon_obs[7:0], ser_data};
         mon_nb++;
         if (ser_strobe) mon_nstb++;
         low_run = 0;
      end else begin
         low_run++;
         if (in_frame) begin
            logic [7:0] w;
            in_frame = 1'b0;
            chk("frame_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               w = sb_q.pop_front();
               chk("frame_len", mon_nb, NB1);
               chk("frame_strobes", mon_nstb, NB1);
               chk("frame_word", 32'(mon_obs), 32'(frame_bits(w)));
               $display("frame word=%02h observed_bits=%03h", w, mon_obs);
            end
         end
      end
   end

   initial begin
      logic [8:0]  fb;
      logic [26:0] exp_dv, obs_dv, exp_sv, obs_sv;
      bit          seen;
      int          n;

      rst = 1'b1; ena = 1'b0; s_data = '0; s_valid = 1'b0;
      ena3 = 1'b1; s_data3 = '0; s_valid3 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_frame", ser_frame, 0);
      chk("rst_data", ser_data, 0);
      chk("rst_strobe", ser_strobe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_level", fifo_level, 0);

      // Single word latency and frame shape.
      ena = 1'b1;
      @(posedge clk); #1;
      push(8'h03, 1'b1);
      fb = frame_bits(8'h03);
      @(negedge clk);
      chk("t1_level_after_push", fifo_level, 1);
      chk("t1_frame_n0", ser_frame, 0);
      @(negedge clk);
      chk("t1_frame_n1", ser_frame, 0);
      chk("t1_busy_n1", busy, 1);
      chk("t1_level_n1", fifo_level, 0);
      @(negedge clk);
      chk("t1_frame_n2", ser_frame, 1);
      chk("t1_msb_n2", ser_data, 0);
      chk("t1_strobe_n2", ser_strobe, 1);
      repeat (NB1 - 1) @(negedge clk);
      chk("t1_frame_last", ser_frame, 1);
      chk("t1_last_bit", ser_data, fb[0]);
      @(negedge clk);
      chk("t1_frame_end", ser_frame, 0);
      chk("t1_busy_end", busy, 0);
      drain("t1_drain");

      // Fill while disabled, overflow refusal, then release.
      ena = 1'b0;
      push(8'hA1, 1'b1);
      push(8'hB2, 1'b1);
      push(8'hC3, 1'b1);
      push(8'hD4, 1'b1);
      @(negedge clk);
      chk("t2_level_full", fifo_level, 4);
      chk("t2_ready_full", s_ready, 0);
      chk("t2_busy_full", busy, 1);
      push(8'hE5, 1'b0);
      @(negedge clk);
      chk("t2_level_refused", fifo_level, 4);
      gap_q.delete();
      ena = 1'b1;
      @(negedge clk);
      chk("t2_ready_after_pop", s_ready, 1);
      chk("t2_level_after_pop", fifo_level, 3);
      drain("t2_drain");
      chk("t2_frame_count", gap_q.size(), 4);
      if (gap_q.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("t2_gap_len", gap_q[i], 2);
      end

      // Stretched bits on the CLK_DIV=3 instance.
      s_data3 = 8'h80; s_valid3 = 1'b1;
      @(posedge clk); #1 s_valid3 = 1'b0;
      n = 0;
      while (!ser_frame3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t3_frame_start", 32'(n < 20), 1);
      fb = frame_bits(8'h80);
      exp_dv = '0; obs_dv = '0; exp_sv = '0; obs_sv = '0;
      for (int c = 0; c < NB1 * 3; c++) begin
         exp_dv[c] = fb[NB1 - 1 - c / 3];
         exp_sv[c] = ((c % 3) == 0);
         obs_dv[c] = ser_data3;
         obs_sv[c] = ser_strobe3 & ser_frame3;
         @(negedge clk);
      end
      chk("t3_data_pattern", 32'(obs_dv), 32'(exp_dv));
      chk("t3_strobe_pattern", 32'(obs_sv), 32'(exp_sv));
      chk("t3_frame_end", ser_frame3, 0);
      $display("div3 frame data=%07h strobe=%07h", obs_dv, obs_sv);

      // Reset in the middle of a frame.
      push(8'hFF, 1'b1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t4_mid_frame", ser_frame, 1);
      chk("t4_mid_data", ser_data, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("t4_frame_rst", ser_frame, 0);
      chk("t4_data_rst", ser_data, 0);
      chk("t4_level_rst", fifo_level, 0);
      chk("t4_ready_rst", s_ready, 1);
      chk("t4_busy_rst", busy, 0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ser_frame) seen = 1'b1;
      end
      chk("t4_no_residual", seen, 0);

      // Simultaneous push and pop at level 2.
      @(posedge clk); #1;
      ena = 1'b0;
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      @(negedge clk);
      chk("t5_level_two", fifo_level, 2);
      @(posedge clk); #1;
      ena = 1'b1;
      push(8'h33, 1'b1);
      @(negedge clk);
      chk("t5_level_pushpop", fifo_level, 2);
      drain("t5_drain");

      // Two back-to-back words (parity 0 then 1 when parity is built in).
      push(8'h03, 1'b1);
      push(8'h07, 1'b1);
      drain("t6_drain");
      chk("t6_queue_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/readout_serializer.md
Name: readout_serializer

Overview:
- Downstream stage of the fast-readout datapath. Accepts 8-bit result words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out MSB-first on a single serial line, with a frame qualifier and a per-bit strobe.
- Sits between the combining datapath and the pad-level output pins.

Parameters:
- DATA_W, 8, word width in bits.
- FIFO_DEPTH, 4, buffered words; power of two, >=2.
- CLK_DIV, 1, clk cycles per serial bit; >=1.
- GAP_BITS, 1, idle bit periods between frames; >=1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  serializer enable; gates start of new frames only.
- s_data  input  DATA_W  word to enqueue.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept; equals !full.
- ser_data  output  1  serial bit, MSB first.
- ser_frame  output  1  high for every bit period of a frame.
- ser_strobe  output  1  one-cycle pulse on the first cycle of each bit period inside a frame.
- busy  output  1  FSM not in IDLE, or FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words held.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers and level go to 0.
  - FSM goes to IDLE.
  - ser_data, ser_frame, ser_strobe and busy go to 0; s_ready goes to 1.
  - Applies mid-frame as well: the frame is aborted and the word is discarded.
- Enqueue:
  - Push occurs when s_valid & s_ready at an edge.
  - s_ready = !full, combinational from level.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: level unchanged.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if ena & !empty, pop the head into the shift register, clear the bit and divider counters, and go to SHIFT. Outputs are 0 in IDLE.
  - SHIFT: ser_frame=1 and ser_data = shreg MSB.
    - Divider counts 0..CLK_DIV-1; ser_strobe=1 when the divider is 0.
    - On divider wrap, shift left and increment the bit counter.
    - After the DATA_W-th bit period, go to GAP.
  - GAP: ser_frame=0 and ser_data=0 for GAP_BITS*CLK_DIV cycles, then return to IDLE.
- Latency:
  - Word pushed at edge N into an empty FIFO with the FSM in IDLE and ena=1: the pop happens at edge N+1.
  - ser_frame=1 with the MSB is visible after edge N+2.
  - A frame occupies exactly DATA_W*CLK_DIV cycles.
  - Back-to-back frames are separated by GAP_BITS*CLK_DIV cycles plus 1 IDLE cycle.
- ena:
  - Deasserting ena mid-frame does not truncate the frame. The current frame and its GAP complete, then the FSM holds in IDLE.
  - The FIFO keeps accepting words while ena=0.
- Outputs ser_data, ser_frame and ser_strobe are driven directly from flops; they are glitch-free.
- Wrap-around: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; level is tracked separately.
- busy = (state!=IDLE) | (level!=0).

Optional Feature:
- Macro: READOUT_PARITY_EN.
- Defined: after the DATA_W data bits, one extra bit period carries even parity, the XOR of the word. ser_frame stays high and ser_strobe pulses for that period; the frame lasts (DATA_W+1)*CLK_DIV cycles.
- Undefined: no parity bit; the frame is DATA_W bit periods, and no parity logic is synthesized.

Decomposition:
- readout_pkg:
  - FSM state enum (IDLE, SHIFT, GAP).
  - Default-width localparams.
  - Function computing counter widths, minimum 1 bit.
- Sub-module readout_fifo:
  - Synchronous FIFO with push/pop/full/empty/level.
  - Parameterised by DATA_W and FIFO_DEPTH.
- FSM, divider and shift register live in readout_serializer.

Test Plan:
- CLK_DIV=1, ena=1: push 0x03 -> after 2 edges ser_frame is high for 8 cycles, ser_data=0,0,0,0,0,0,1,1, and ser_strobe is high every cycle; then ser_frame is low for 1 GAP cycle plus 1 IDLE cycle, and busy falls.
- ena=0: push 0xA1, 0xB2, 0xC3, 0xD4 -> fifo_level=4 and s_ready=0; a fifth push of 0xE5 is refused. Raise ena -> four frames appear in order A1, B2, C3, D4, and s_ready rises after the first pop.
- CLK_DIV=3: push 0x80 -> MSB=1 held for 3 cycles, then seven 0 bits of 3 cycles each; ser_strobe pulses on cycles 0, 3, 6, and so on, 8 pulses in total.
- Reset mid-frame: push 0xFF, assert rst during bit 4 -> next edge ser_frame=0, ser_data=0, fifo_level=0, s_ready=1; no residual frame follows.
- Simultaneous push/pop: level=2, push and pop in the same cycle -> level stays 2 and data order is preserved.
- READOUT_PARITY_EN defined: push 0x03 then 0x07 -> frames are 9 bits long with parity bits 0 and 1 respectively.
